ctrl_issue: RTL and testbench

- Upstream issue stage for the control-word delay line (ctrl_arr).
- Accepts control words from the sequencer over valid/ready and buffers them in a small FIFO.
- Drives exactly one word per clock into the delay line: a queued word, or NOP_WORD when there is nothing to issue.
- Mirrors the delay line's latency with a shadow valid pipe. This lets the consumer know when ctrl_arr's output holds a real word, and reports in-flight/idle status and flush completion.

---
 rtl/ctrl_issue_pkg.sv | 17 +
 rtl/ctrl_issue_fifo.sv | 76 +++++++
 rtl/ctrl_issue.sv | 139 +++++++++++++
 tb/tb_ctrl_issue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_issue_pkg.sv
// Shared types, constants and width helper for the control-word issue stage.
package ctrl_issue_pkg;

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int ctr_w(input int max_val);
      if (max_val < 2) begin
         return 1;
      end else begin
         return $clog2(max_val + 1);
      end
   endfunction

endpackage

// File: rtl/ctrl_issue_fifo.sv
// Synchronous FIFO with synchronous clear; head is the oldest entry.
module ctrl_issue_fifo
   import ctrl_issue_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push_i,
   input  logic                        pop_i,
   input  logic                        clear_i,
   input  logic [WIDTH-1:0]            data_i,
   output logic [WIDTH-1:0]            head_o,
   output logic [ctr_w(DEPTH)-1:0]     count_o,
   output logic                        full_o,
   output logic                        empty_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = ctr_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok_s, pop_ok_s;

   assign full_o    = (cnt_q == CNT_W'(DEPTH));
   assign empty_o   = (cnt_q == {CNT_W{1'b0}});
   assign push_ok_s = push_i && !full_o;
   assign pop_ok_s  = pop_i && !empty_o;
   assign head_o    = mem_q[rd_ptr_q];
   assign count_o   = cnt_q;

   // Pointer and occupancy next state; pointers wrap because DEPTH is a power of 2.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clear_i) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         cnt_d    = {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         else           wr_ptr_d = wr_ptr_q;
         if (pop_ok_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         else           rd_ptr_d = rd_ptr_q;
         case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage array, written on accepted push.
   always_ff @(posedge clk) begin
      if (push_ok_s && !clear_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/ctrl_issue.sv
// Issue stage feeding the ctrl_arr delay line, with a shadow valid pipe for retire tracking.
// Optional issue throttling is enabled by defining CTRL_ISSUE_THROTTLE_EN.
module ctrl_issue
   import ctrl_issue_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 8,
   parameter int               LENGTH   = 5,
   parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_DEFAULT)
`ifdef CTRL_ISSUE_THROTTLE_EN
   ,parameter int              ISSUE_GAP = 2
`endif
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         hold,
   input  logic                         flush,
   output logic [WIDTH-1:0]             out,
   output logic                         out_vld,
   output logic                         retire,
   output logic [ctr_w(DEPTH)-1:0]      count,
   output logic [ctr_w(LENGTH+2)-1:0]   inflight,
   output logic                         idle
);
   localparam int CNT_W = ctr_w(DEPTH);
   localparam int IF_W  = ctr_w(LENGTH + 2);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d, head_s;
   logic             out_vld_q, out_vld_d;
   logic [LENGTH:0]  vpipe_q;
   logic [IF_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0] count_s;
   logic             full_s, empty_s, flush_s, push_s, issue_s, gap_ok_s, dec_s;

   assign flush_s  = flush && (state_q == RUN);
   assign in_ready = !full_s && (state_q == RUN) && !rst;
   assign push_s   = in_valid && in_ready;
   assign issue_s  = (state_q == RUN) && !flush_s && !hold && !empty_s && gap_ok_s;
   assign dec_s    = vpipe_q[LENGTH] && (inflight_q != {IF_W{1'b0}});

   ctrl_issue_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s),
      .pop_i   (issue_s),
      .clear_i (flush_s),
      .data_i  (in_data),
      .head_o  (head_s),
      .count_o (count_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

`ifdef CTRL_ISSUE_THROTTLE_EN
   localparam int GAP_W = ctr_w(ISSUE_GAP);
   logic [GAP_W-1:0] gap_q, gap_d;

   // Gap counter: reload on issue, count down to zero, cleared on flush.
   always_comb begin
      gap_d = gap_q;
      if (flush_s)                       gap_d = {GAP_W{1'b0}};
      else if (issue_s)                  gap_d = GAP_W'(ISSUE_GAP);
      else if (gap_q != {GAP_W{1'b0}})   gap_d = gap_q - GAP_W'(1);
      else                               gap_d = gap_q;
   end

   // Gap counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) gap_q <= {GAP_W{1'b0}};
      else     gap_q <= gap_d;
   end

   assign gap_ok_s = (gap_q == {GAP_W{1'b0}});
`else
   assign gap_ok_s = 1'b1;
`endif

   // FSM, issue word and in-flight counter next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (flush) state_d = FLUSH;
            else       state_d = RUN;
         end
         FLUSH: begin
            if (inflight_q == {IF_W{1'b0}}) state_d = RUN;
            else                            state_d = FLUSH;
         end
         default: state_d = RUN;
      endcase

      if (issue_s) begin
         out_d     = head_s;
         out_vld_d = 1'b1;
      end else begin
         out_d     = NOP_WORD;
         out_vld_d = 1'b0;
      end

      case ({issue_s, dec_s})
         2'b10:   inflight_d = inflight_q + IF_W'(1);
         2'b01:   inflight_d = inflight_q - IF_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // State, output word and shadow pipe registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         out_q      <= NOP_WORD;
         out_vld_q  <= 1'b0;
         vpipe_q    <= {(LENGTH+1){1'b0}};
         inflight_q <= {IF_W{1'b0}};
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         vpipe_q    <= {vpipe_q[LENGTH-1:0], out_vld_q};
         inflight_q <= inflight_d;
      end
   end

   assign out      = out_q;
   assign out_vld  = out_vld_q;
   assign retire   = vpipe_q[LENGTH];
   assign count    = count_s;
   assign inflight = inflight_q;
   assign idle     = (count_s == {CNT_W{1'b0}}) && (inflight_q == {IF_W{1'b0}}) && (state_q == RUN);

endmodule

// File: tb/tb_ctrl_issue.sv
// Directed self-checking bench for ctrl_issue (default build, LENGTH=5, DEPTH=8).
module tb_ctrl_issue;
   localparam int WIDTH  = 32;
   localparam int DEPTH  = 8;
   localparam int LENGTH = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [WIDTH-1:0]  in_data = 32'h0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              hold = 1'b0;
   logic              flush = 1'b0;
   logic [WIDTH-1:0]  out_w;
   logic              out_vld;
   logic              retire;
   logic [3:0]        count;
   logic [2:0]        inflight;
   logic              idle;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ctrl_issue #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .LENGTH (LENGTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .hold     (hold),
      .flush    (flush),
      .out      (out_w),
      .out_vld  (out_vld),
      .retire   (retire),
      .count    (count),
      .inflight (inflight),
      .idle     (idle)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!idle && n < budget) begin
         tick();
         n++;
      end
      check_eq("wait_idle", 32'(idle), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_if [12] = '{0, 1, 2, 3, 3, 3, 3, 3, 2, 1, 0, 0};

      // reset state
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_out", out_w, 32'h0);
      check_eq("rst_out_vld", 32'(out_vld), 32'd0);
      check_eq("rst_retire", 32'(retire), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_inflight", 32'(inflight), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_eq("rel_idle", 32'(idle), 32'd1);
      check_eq("rel_in_ready", 32'(in_ready), 32'd1);

      // three back-to-back words: issue at E2..E4, retire at E8..E10
      in_valid = 1'b1;
      in_data  = 32'hA1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         in_data  = (k == 1) ? 32'hA2 : 32'hA3;
         in_valid = (k < 3);
         check_eq("t1_vld", 32'(out_vld), 32'(k >= 2 && k <= 4));
         if (k >= 2 && k <= 4) check_eq("t1_out", out_w, 32'hA0 + 32'(k - 1));
         check_eq("t1_retire", 32'(retire), 32'(k >= 8 && k <= 10));
         check_eq("t1_inflight", 32'(inflight), 32'(exp_if[k-1]));
      end
      check_eq("t1_idle", 32'(idle), 32'd1);

      // hold and fill: ninth word refused, then ordered drain
      hold = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_data = 32'hB0 + 32'(k);
         tick();
      end
      check_eq("t2_count_full", 32'(count), 32'd8);
      check_eq("t2_in_ready", 32'(in_ready), 32'd0);
      in_data = 32'hB8;
      tick();
      check_eq("t2_count_9th", 32'(count), 32'd8);
      in_valid = 1'b0;
      hold = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check_eq("t2_vld", 32'(out_vld), 32'd1);
         check_eq("t2_out", out_w, 32'hB0 + 32'(k));
      end
      check_eq("t2_count_empty", 32'(count), 32'd0);
      wait_idle(20);

      // full FIFO, push attempt on the same edge as a pop
      hold = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_data = 32'hC0 + 32'(k);
         tick();
      end
      hold = 1'b0;
      in_data = 32'hC8;
      tick();
      in_valid = 1'b0;
      check_eq("t3_count", 32'(count), 32'd7);
      check_eq("t3_out0", out_w, 32'hC0);
      for (int k = 1; k < 8; k++) begin
         tick();
         check_eq("t3_out", out_w, 32'hC0 + 32'(k));
      end
      tick();
      check_eq("t3_no_c8", 32'(out_vld), 32'd0);
      check_eq("t3_count_end", 32'(count), 32'd0);
      wait_idle(20);

      // flush with 3 in flight and 4 queued
      hold = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         in_data = 32'hD0 + 32'(k);
         tick();
      end
      in_valid = 1'b0;
      hold = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("t4_out", out_w, 32'hD0 + 32'(k));
      end
      check_eq("t4_count_pre", 32'(count), 32'd4);
      check_eq("t4_inflight_pre", 32'(inflight), 32'd3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_eq("t4_count_flush", 32'(count), 32'd0);
      check_eq("t4_in_ready_flush", 32'(in_ready), 32'd0);
      check_eq("t4_vld_flush", 32'(out_vld), 32'd0);
      check_eq("t4_idle_flush", 32'(idle), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check_eq("t4_retire", 32'(retire), 32'(k >= 3 && k <= 5));
         check_eq("t4_vld", 32'(out_vld), 32'd0);
         check_eq("t4_in_ready", 32'(in_ready), 32'(k >= 7));
         check_eq("t4_idle", 32'(idle), 32'(k >= 7));
      end

      // asynchronous reset with 4 words in flight and 2 queued
      hold = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_data = 32'hE0 + 32'(k);
         tick();
      end
      in_valid = 1'b0;
      hold = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check_eq("t5_inflight_pre", 32'(inflight), 32'd4);
      check_eq("t5_count_pre", 32'(count), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      check_eq("t5_out", out_w, 32'h0);
      check_eq("t5_vld", 32'(out_vld), 32'd0);
      check_eq("t5_retire", 32'(retire), 32'd0);
      check_eq("t5_count", 32'(count), 32'd0);
      check_eq("t5_inflight", 32'(inflight), 32'd0);
      check_eq("t5_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check_eq("t5_post_retire", 32'(retire), 32'd0);
         check_eq("t5_post_vld", 32'(out_vld), 32'd0);
      end
      check_eq("t5_idle", 32'(idle), 32'd1);

`ifdef CTRL_ISSUE_THROTTLE_EN
      // throttled issue: one valid word every third cycle
      hold = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data = 32'hF0 + 32'(k);
         tick();
      end
      in_valid = 1'b0;
      hold = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         check_eq("t6_vld", 32'(out_vld), 32'((k % 3) == 1));
         if ((k % 3) == 1) check_eq("t6_out", out_w, 32'hF0 + 32'((k - 1) / 3));
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
